// File: rtl/ysyx_22050550_mul_ctrl.sv
// Request/response controller between the EXU and an external 64x64 multiplier.
// Defining YSYX_22050550_MULFUSE_EN adds a one-entry result cache that bypasses the multiplier on a repeat.
module ysyx_22050550_mul_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_word,
    input  logic [63:0] req_src1,
    input  logic [63:0] req_src2,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        mul_valid,
    output logic        mul_flush,
    output logic        mul_w,
    output logic [1:0]  mul_signed,
    output logic [63:0] mul_a,
    output logic [63:0] mul_b,
    input  logic        mul_ready,
    input  logic        mul_out_valid,
    input  logic [63:0] mul_res_h,
    input  logic [63:0] mul_res_l
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic        word_q;
    logic [1:0]  sig_q;
    logic [63:0] src1_q;
    logic [63:0] src2_q;
    logic [63:0] data_q;

    logic        accept;
    logic [1:0]  acc_op;
    logic [1:0]  acc_sig;
    logic [63:0] res_sel;
    logic        hit;
    logic [63:0] hit_data;

    assign req_ready  = (state == IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign mul_valid  = (state == ISSUE) && !flush;
    assign mul_flush  = (state == WAIT) && flush;
    assign resp_valid = (state == RESP) && !flush;
    assign resp_data  = data_q;
    assign mul_w      = word_q;
    assign mul_signed = sig_q;
    assign mul_a      = src1_q;
    assign mul_b      = src2_q;

    // A word request is always a MULW, whatever op accompanies it.
    always_comb begin
        acc_op = req_word ? 2'b00 : req_op;
        case (acc_op)
            2'b00, 2'b01: acc_sig = 2'b11;
            2'b10:        acc_sig = 2'b10;
            default:      acc_sig = 2'b00;
        endcase
    end

    always_comb begin
        if (word_q)
            res_sel = {{32{mul_res_l[31]}}, mul_res_l[31:0]};
        else if (op_q == 2'b00)
            res_sel = mul_res_l;
        else
            res_sel = mul_res_h;
    end

`ifdef YSYX_22050550_MULFUSE_EN
    logic        c_valid;
    logic [1:0]  c_sig;
    logic [63:0] c_src1;
    logic [63:0] c_src2;
    logic [63:0] c_h;
    logic [63:0] c_l;

    assign hit = c_valid && !req_word && (c_src1 == req_src1) && (c_src2 == req_src2)
                 && (c_sig == acc_sig);
    assign hit_data = (acc_op == 2'b00) ? c_l : c_h;

    // Flush never invalidates: the entry holds a completed product, not in-flight state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            c_valid <= 1'b0;
            c_sig   <= '0;
            c_src1  <= '0;
            c_src2  <= '0;
            c_h     <= '0;
            c_l     <= '0;
        end else if (state == WAIT && !flush && mul_out_valid && !word_q) begin
            c_valid <= 1'b1;
            c_sig   <= sig_q;
            c_src1  <= src1_q;
            c_src2  <= src2_q;
            c_h     <= mul_res_h;
            c_l     <= mul_res_l;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= '0;
            word_q <= 1'b0;
            sig_q  <= '0;
            src1_q <= '0;
            src2_q <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= acc_op;
                        word_q <= req_word;
                        sig_q  <= acc_sig;
                        src1_q <= req_src1;
                        src2_q <= req_src2;
                        if (hit) begin
                            data_q <= hit_data;
                            state  <= RESP;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush)
                        state <= IDLE;
                    else if (mul_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (mul_out_valid) begin
                        data_q <= res_sel;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (flush || resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050550_mul_ctrl.sv
// Scoreboard bench for ysyx_22050550_mul_ctrl: directed corner cases then randomized traffic
// against a multiplier model; honours YSYX_22050550_MULFUSE_EN for the cache-hit scenario.
`timescale 1ns/1ps
module tb_ysyx_22050550_mul_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic        req_word = 1'b0;
    logic [63:0] req_src1 = '0;
    logic [63:0] req_src2 = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        mul_valid;
    logic        mul_flush;
    logic        mul_w;
    logic [1:0]  mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic        mul_ready;
    logic        mul_out_valid;
    logic [63:0] mul_res_h;
    logic [63:0] mul_res_l;

    // Multiplier inputs come from the random model or from directed stimulus.
    logic        model_en = 1'b0;
    logic        m_ready, m_out_valid;
    logic [63:0] m_h, m_l;
    logic        d_ready = 1'b0;
    logic        d_out_valid = 1'b0;
    logic [63:0] d_h = '0;
    logic [63:0] d_l = '0;
    assign mul_ready     = model_en ? m_ready     : d_ready;
    assign mul_out_valid = model_en ? m_out_valid : d_out_valid;
    assign mul_res_h     = model_en ? m_h         : d_h;
    assign mul_res_l     = model_en ? m_l         : d_l;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    ysyx_22050550_mul_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mul_valid(mul_valid), .mul_flush(mul_flush), .mul_w(mul_w), .mul_signed(mul_signed),
        .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready), .mul_out_valid(mul_out_valid),
        .mul_res_h(mul_res_h), .mul_res_l(mul_res_l)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b,
                                          input logic sa, input logic sb);
        logic [127:0] xa, xb;
        xa = sa ? {{64{a[63]}}, a} : {64'd0, a};
        xb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        return xa * xb;
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        if (word) begin
            p = prod(a, b, 1'b1, 1'b1);
            return {{32{p[31]}}, p[31:0]};
        end
        case (op)
            2'b00: begin p = prod(a, b, 1'b1, 1'b1); return p[63:0]; end
            2'b01: p = prod(a, b, 1'b1, 1'b1);
            2'b10: p = prod(a, b, 1'b1, 1'b0);
            default: p = prod(a, b, 1'b0, 1'b0);
        endcase
        return p[127:64];
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: every completed response handshake pops the oldest expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL resp_unexpected: got %h expected no response", resp_data);
                end else begin
                    chk("resp_data", resp_data, exp_q.pop_front());
                end
            end
        end
    end

    // Multiplier model: random accept delay and latency, true product of what it was handed.
    initial begin
        logic [127:0] p;
        int m_cnt;
        logic m_busy;
        m_ready = 1'b0; m_out_valid = 1'b0; m_h = '0; m_l = '0; m_busy = 1'b0; m_cnt = 0;
        forever begin
            @(negedge clock);
            m_ready = 1'b0;
            m_out_valid = 1'b0;
            if (!reset || !model_en) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (mul_flush) m_busy = 1'b0;
                else if (m_cnt == 0) begin m_out_valid = 1'b1; m_busy = 1'b0; end
                else m_cnt--;
            end else if (mul_valid && $urandom_range(0, 2) != 0) begin
                p = prod(mul_a, mul_b, mul_signed[1], mul_signed[0]);
                m_h = p[127:64];
                m_l = p[63:0];
                m_ready = 1'b1;
                m_busy = 1'b1;
                m_cnt = $urandom_range(0, 3);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_mul_valid"}, mul_valid, 0);
        chk({tag, "_mul_flush"}, mul_flush, 0);
        chk({tag, "_mul_w"}, mul_w, 0);
        chk({tag, "_mul_signed"}, mul_signed, 0);
        chk({tag, "_mul_a"}, mul_a, 0);
        chk({tag, "_mul_b"}, mul_b, 0);
    endtask

    task automatic dir_txn(input string tag, input logic [1:0] op, input logic word,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] h, input logic [63:0] l,
                           input logic [1:0] exp_sig, input logic [63:0] exp_data, input int stall);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = op; req_word = word; req_src1 = a; req_src2 = b;
        @(negedge clock);
        chk({tag, "_req_ready"}, req_ready, 1);
        exp_q.push_back(exp_data);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        chk({tag, "_mul_valid"}, mul_valid, 1);
        chk({tag, "_mul_signed"}, mul_signed, exp_sig);
        chk({tag, "_mul_w"}, mul_w, word);
        chk({tag, "_mul_a"}, mul_a, a);
        chk({tag, "_mul_b"}, mul_b, b);
        d_ready = 1'b1;
        @(posedge clock); #1;
        d_ready = 1'b0; d_out_valid = 1'b1; d_h = h; d_l = l;
        @(negedge clock);
        chk({tag, "_wait_resp_valid"}, resp_valid, 0);
        @(posedge clock); #1;
        d_out_valid = 1'b0; d_h = ~h; d_l = ~l;
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            chk({tag, "_stall_valid"}, resp_valid, 1);
            chk({tag, "_stall_data"}, resp_data, exp_data);
            chk({tag, "_stall_req_ready"}, req_ready, 0);
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(negedge clock);
        chk({tag, "_resp_valid"}, resp_valid, 1);
        @(posedge clock); #1;
        resp_ready = 1'b0;
        @(negedge clock);
        chk({tag, "_idle_req_ready"}, req_ready, 1);
        chk({tag, "_idle_resp_valid"}, resp_valid, 0);
        @(posedge clock); #1;
    endtask

    // where: 1 = flush in ISSUE, 2 = in WAIT with coincident result, 3 = in RESP with resp_ready
    task automatic flush_test(input string tag, input int where);
        req_valid = 1'b1; req_op = 2'b01; req_word = 1'b0;
        req_src1 = {$urandom, $urandom}; req_src2 = {$urandom, $urandom};
        @(negedge clock);
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (where >= 2) begin
            @(negedge clock); d_ready = 1'b1;
            @(posedge clock); #1; d_ready = 1'b0;
        end
        if (where == 3) begin
            d_out_valid = 1'b1;
            @(posedge clock); #1; d_out_valid = 1'b0;
        end
        flush = 1'b1; resp_ready = 1'b1; d_out_valid = (where == 2);
        @(negedge clock);
        chk({tag, "_mul_valid"}, mul_valid, 0);
        chk({tag, "_mul_flush"}, mul_flush, (where == 2));
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_req_ready_during"}, req_ready, 0);
        @(posedge clock); #1;
        flush = 1'b0; d_out_valid = 1'b0;
        @(negedge clock);
        chk({tag, "_mul_flush_after"}, mul_flush, 0);
        chk({tag, "_req_ready_after"}, req_ready, 1);
        chk({tag, "_resp_valid_after"}, resp_valid, 0);
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic rand_txn(input logic [1:0] op, input logic word,
                            input logic [63:0] a, input logic [63:0] b, input int fpct);
        bit got, done;
        got = 1'b0; done = 1'b0;
        req_valid = 1'b1; req_op = op; req_word = word; req_src1 = a; req_src2 = b;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock);
            if (req_ready) got = 1'b1;
            else begin @(posedge clock); #1; end
        end
        chk("rand_accept", got, 1);
        if (!got) begin req_valid = 1'b0; return; end
        exp_q.push_back(ref_result(op, word, a, b));
        @(posedge clock); #1;
        req_valid = 1'b0; req_src1 = {$urandom, $urandom}; req_src2 = {$urandom, $urandom};
        for (int c = 0; c < 100 && !done; c++) begin
            resp_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) < fpct) begin
                void'(exp_q.pop_back());
                flush = 1'b1;
                @(posedge clock); #1;
                flush = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clock);
                if (resp_valid && resp_ready) done = 1'b1;
                @(posedge clock); #1;
            end
        end
        resp_ready = 1'b0;
        chk("rand_resp_timeout", done, 1);
    endtask

    initial begin
        logic [63:0] a, b;
        logic [1:0] op;
        logic word;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk_reset_outputs("reset");
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("reset_release_req_ready", req_ready, 1);
        @(posedge clock); #1;

        dir_txn("mul", 2'b00, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 2'b11, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        dir_txn("mulw", 2'b00, 1'b1, 64'h1234, 64'h5678,
                64'h0, 64'h0000_0001_8000_0000, 2'b11, 64'hFFFF_FFFF_8000_0000, 0);
        dir_txn("mulw_illegal_op", 2'b10, 1'b1, 64'h99, 64'h77,
                64'h5555, 64'h0000_0000_7FFF_FFFF, 2'b11, 64'h0000_0000_7FFF_FFFF, 0);
        dir_txn("mulhu", 2'b11, 1'b0, '1, '1,
                64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        dir_txn("mulhsu_stall", 2'b10, 1'b0, 64'hDEAD_BEEF, 64'hCAFE,
                64'h0123_4567_89AB_CDEF, 64'h42, 2'b10, 64'h0123_4567_89AB_CDEF, 5);

        flush_test("flush_issue", 1);
        flush_test("flush_wait", 2);
        flush_test("flush_resp", 3);

        // Reset while waiting on the multiplier
        req_valid = 1'b1; req_op = 2'b00; req_word = 1'b1; req_src1 = 64'h55; req_src2 = 64'h66;
        @(negedge clock);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock); d_ready = 1'b1;
        @(posedge clock); #1;
        d_ready = 1'b0; reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_no_mul_flush", mul_flush, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk_reset_outputs("rst_mid");
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_req_ready", req_ready, 1);
        @(posedge clock); #1;

        // MULH then MUL on the same operands
        a = 64'h0BAD_F00D_1234_5678; b = 64'hFEDC_BA98_7654_3210;
        dir_txn("fuse_first", 2'b01, 1'b0, a, b, 64'hAAAA_0000_BBBB_1111,
                64'h1111_2222_3333_4444, 2'b11, 64'hAAAA_0000_BBBB_1111, 0);
`ifdef YSYX_22050550_MULFUSE_EN
        req_valid = 1'b1; req_op = 2'b00; req_word = 1'b0; req_src1 = a; req_src2 = b;
        @(negedge clock);
        chk("fuse_hit_req_ready", req_ready, 1);
        exp_q.push_back(64'h1111_2222_3333_4444);
        @(posedge clock); #1;
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clock);
        chk("fuse_hit_mul_valid", mul_valid, 0);
        chk("fuse_hit_resp_valid", resp_valid, 1);
        chk("fuse_hit_resp_data", resp_data, 64'h1111_2222_3333_4444);
        @(posedge clock); #1;
        resp_ready = 1'b0;
        @(negedge clock);
        chk("fuse_hit_idle", req_ready, 1);
        chk("fuse_hit_no_issue", mul_valid, 0);
        @(posedge clock); #1;
`else
        dir_txn("fuse_second", 2'b00, 1'b0, a, b, 64'h9999,
                64'h1111_2222_3333_4444, 2'b11, 64'h1111_2222_3333_4444, 0);
`endif

        model_en = 1'b1;
        a = rand_operand(); b = rand_operand();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                a = rand_operand();
                b = rand_operand();
            end
            op = 2'($urandom_range(0, 3));
            word = ($urandom_range(0, 3) == 0);
            rand_txn(op, word, a, b, 8);
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end

        repeat (5) @(posedge clock);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end
endmodule

// File: doc/ysyx_22050550_mul_ctrl.md
YSYX_22050550_MUL_CTRL -- requirements
Module: ysyx_22050550_mul_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset).
REQ-003 SHALL have port: req_valid  input  1  EXU multiply request valid.
REQ-004 SHALL have port: req_ready  output  1  controller can accept request.
REQ-005 SHALL have port: req_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have port: req_word  input  1  MULW; legal only with req_op=00.
REQ-007 SHALL have ports: req_src1, req_src2  input  64 each  rs1, rs2 operands.
REQ-008 SHALL have port: flush  input  1  pipeline flush; kills in-flight op.
REQ-009 SHALL have ports: resp_valid  output  1; resp_ready  input  1; resp_data  output  64  result to WBU.
REQ-010 SHALL have multiplier-side outputs: mul_valid 1, mul_flush 1, mul_w 1, mul_signed 2, mul_a 64 (multiplicand = src1), mul_b 64 (multiplier = src2).
REQ-011 SHALL have multiplier-side inputs: mul_ready 1, mul_out_valid 1, mul_res_h 64, mul_res_l 64.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 req_ready SHALL be 1 only in IDLE with flush=0; accept = req_valid & req_ready; on accept latch op, word, src1, src2 and go ISSUE.
REQ-014 ISSUE: mul_valid=1 with latched operands; on mul_ready=1 same cycle go WAIT; else hold ISSUE, operands stable.
REQ-015 mul_signed SHALL be 11 for MUL/MULH/MULW, 10 for MULHSU, 00 for MULHU; mul_w = latched word.
REQ-016 WAIT: on mul_out_valid=1 capture selected result into resp_data register, go RESP.
REQ-017 Result select: MUL -> mul_res_l; MULH/MULHSU/MULHU -> mul_res_h; MULW -> mul_res_l[31:0] sign-extended to 64.
REQ-018 RESP: resp_valid=1, resp_data stable; on resp_ready=1 go IDLE; no new accept in that same cycle.
REQ-019 Latency (no stall, no fuse): accept cycle t, mul_valid at t+1, resp_valid 1 cycle after mul_out_valid.
REQ-020 flush in ISSUE: go IDLE, mul_valid forced 0 that cycle.
REQ-021 flush in WAIT: mul_flush=1 for exactly that cycle, go IDLE; mul_out_valid coincident with flush discarded.
REQ-022 flush in RESP: drop response, resp_valid=0 that cycle, go IDLE, even if resp_ready=1.
REQ-023 mul_flush SHALL be 0 in every state other than WAIT.
REQ-024 Illegal req_word=1 with req_op!=00 SHALL be treated as MULW.

Reset
REQ-025 reset=0 at a rising edge SHALL force IDLE, clear operand/result registers, regardless of state.
REQ-026 During and after reset: req_ready=1 (once reset=1 and flush=0), resp_valid=0, resp_data=0, mul_valid=0, mul_flush=0, mul_w=0, mul_signed=00, mul_a=mul_b=0.
REQ-027 Reset mid-operation SHALL NOT assert mul_flush; multiplier shares same reset.

Configuration
REQ-028 Macro YSYX_22050550_MULFUSE_EN defined: one-entry result cache {valid, src1, src2, mul_signed, res_h, res_l}, filled on every non-word completion in WAIT.
REQ-029 With it: accept with word=0, cache valid, identical src1, src2, mul_signed -> skip ISSUE/WAIT, go directly RESP next cycle with result selected from cache; mul_valid stays 0.
REQ-030 Cache invalidated only by reset; flush does not invalidate; MULW never fills or hits.
REQ-031 Macro undefined: no cache storage; every request uses full ISSUE/WAIT path.

Verification
REQ-032 MUL src1=7, src2=-3 (0xFFFF_FFFF_FFFF_FFFD), mul_res_l=0xFFFF_FFFF_FFFF_FFEB -> mul_signed=11, resp_data=0xFFFF_FFFF_FFFF_FFEB.
REQ-033 MULW, mul_res_l=0x0000_0001_8000_0000 -> resp_data=0xFFFF_FFFF_8000_0000, mul_w=1.
REQ-034 MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF, mul_res_h=0xFFFF_FFFF_FFFF_FFFE -> mul_signed=00, resp_data=0xFFFF_FFFF_FFFF_FFFE.
REQ-035 flush in WAIT coincident with mul_out_valid -> mul_flush=1 one cycle, resp_valid never asserts, req_ready=1 next cycle.
REQ-036 resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_data stable 5 cycles, req_ready=0 throughout.
REQ-037 MULFUSE_EN: MULH then MUL, same operands -> second op: mul_valid never 1, resp_valid 1 cycle after accept, resp_data = cached res_l.
